// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
//   Shares one SRAM-like memory bus between the instruction-fetch port and
//   the load/store port of the 5-stage core. Only one bus transaction is
//   ever outstanding. When both ports ask in the same idle cycle the
//   DATA_FIRST parameter decides who wins; the loser simply keeps waiting.
//
// Ports
//   clk, rst                        clock and asynchronous active-high reset
//   inst_req/inst_addr              fetch request and word address
//   inst_flush                      exception redirect, drops a pending fetch result
//   inst_rdata/inst_data_ok         fetch data and one-cycle completion pulse
//   data_req/wr/wen/addr/wdata      load/store request
//   data_rdata/data_data_ok         load data and one-cycle completion pulse
//   bus_req/wr/wen/addr/wdata       shared bus request (driven from latched copy)
//   bus_addr_ok/data_ok/rdata       shared bus responses
//   stall_o                         pipeline stall while any port awaits data

module cpu_bus_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_flush,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arbStateT;

  typedef enum logic {
    OWNER_INST,
    OWNER_DATA
  } ownerT;

  arbStateT    state;
  arbStateT    nextState;
  ownerT       owner;
  logic        discard;
  logic [31:0] addrReg;
  logic        wrReg;
  logic [3:0]  wenReg;
  logic [31:0] wdataReg;

  logic        grant;
  logic        grantData;
  logic        completion;
  logic        flushHit;
  logic        instOk;
  logic        dataOk;

  // State register. Reset drops any transaction in flight on the floor;
  // because completion is only ever decoded outside IDLE, no data_ok pulse
  // can escape while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and completion decode. A grant is only ever made from IDLE,
  // and every completion returns to IDLE, so there is always at least one
  // idle cycle between back-to-back transactions. A bus_data_ok that shows
  // up in IDLE, or in REQ before the address was accepted, falls through
  // the case arms untouched and is therefore ignored.
  always_comb begin
    nextState  = state;
    grant      = 1'b0;
    grantData  = 1'b0;
    completion = 1'b0;
    case (state)
      IDLE: begin
        if (inst_req || data_req) begin
          grant     = 1'b1;
          grantData = data_req && (!inst_req || DATA_FIRST);
          nextState = REQ;
        end
      end
      REQ: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            completion = 1'b1;
            nextState  = IDLE;
          end else begin
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_data_ok) begin
          completion = 1'b1;
          nextState  = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Completion routing. A flush arriving in the very cycle the fetch
  // completes is honoured as well, since the pipeline has already been
  // redirected and must not consume stale instruction data. Read data is
  // only presented alongside its pulse so that idle and reset cycles show 0.
  always_comb begin
    flushHit   = 1'b0;
    instOk     = 1'b0;
    dataOk     = 1'b0;
    inst_rdata = 32'h0;
    data_rdata = 32'h0;
    flushHit   = (state != IDLE) && (owner == OWNER_INST) && inst_flush;
    instOk     = completion && (owner == OWNER_INST) && !discard && !flushHit;
    dataOk     = completion && (owner == OWNER_DATA);
    if (instOk) begin
      inst_rdata = bus_rdata;
    end
    if (dataOk) begin
      data_rdata = bus_rdata;
    end
  end

  // Request capture. Everything the bus needs is copied at grant time so
  // the requesters can wiggle their inputs afterwards without disturbing
  // the bus. Fetches are always reads with no byte enables or write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= OWNER_INST;
      addrReg  <= 32'h0;
      wrReg    <= 1'b0;
      wenReg   <= 4'b0000;
      wdataReg <= 32'h0;
    end else if (grant) begin
      if (grantData) begin
        owner    <= OWNER_DATA;
        addrReg  <= data_addr;
        wrReg    <= data_wr;
        wenReg   <= data_wen;
        wdataReg <= data_wdata;
      end else begin
        owner    <= OWNER_INST;
        addrReg  <= inst_addr;
        wrReg    <= 1'b0;
        wenReg   <= 4'b0000;
        wdataReg <= 32'h0;
      end
    end
  end

  // Discard flag. Once a fetch is flushed its bus transaction still has to
  // run to completion (the memory side cannot be cancelled), so we just
  // remember to swallow the result and forget the flag when it arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard <= 1'b0;
    end else if (completion) begin
      discard <= 1'b0;
    end else if (flushHit) begin
      discard <= 1'b1;
    end
  end

  assign bus_req      = (state == REQ);
  assign bus_wr       = wrReg;
  assign bus_wen      = wenReg;
  assign bus_addr     = addrReg;
  assign bus_wdata    = wdataReg;
  assign inst_data_ok = instOk;
  assign data_data_ok = dataOk;
  assign stall_o      = (inst_req & ~inst_data_ok) | (data_req & ~data_data_ok);

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter
//   Directed bench for cpu_bus_arbiter. A transaction-level reference model
//   predicts every output on every falling edge, an invariant watcher guards
//   the bus handshake, and the directed scenarios add hand-computed literal
//   expectations at the interesting cycles.

module tb_cpu_bus_arbiter;

  localparam bit DATA_FIRST_TB = 1'b1;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_flush;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        stall_o;

  int errors = 0;
  int checks = 0;

  cpu_bus_arbiter #(.DATA_FIRST(DATA_FIRST_TB)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_flush   (inst_flush),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wen     (data_wen),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_wen      (bus_wen),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .stall_o      (stall_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports a FAIL line when it disagrees.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Move to the next stimulus slot, just after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: is a transaction in flight, has its address
  // been accepted, who owns it, what was captured, and was it flushed.
  bit          mBusy;
  bit          mAccepted;
  bit          mOwnData;
  bit          mDropped;
  logic [31:0] mAddr;
  logic        mWr;
  logic [3:0]  mWen;
  logic [31:0] mWdata;

  // Compare process: on every falling edge predict all outputs from the
  // model plus the current inputs, compare, then advance the model to
  // where it will be after the coming rising edge.
  always @(negedge clk) begin : compareBlk
    bit complete;
    bit flushNow;
    bit expInstOk;
    bit expDataOk;
    bit expBusReq;
    if (rst) begin
      mBusy = 0; mAccepted = 0; mOwnData = 0; mDropped = 0;
      mAddr = '0; mWr = 0; mWen = '0; mWdata = '0;
      checkOutput("rstBusReq", bus_req, 0);
      checkOutput("rstBusAddr", bus_addr, 0);
      checkOutput("rstBusWr", bus_wr, 0);
      checkOutput("rstBusWen", bus_wen, 0);
      checkOutput("rstBusWdata", bus_wdata, 0);
      checkOutput("rstInstOk", inst_data_ok, 0);
      checkOutput("rstDataOk", data_data_ok, 0);
      checkOutput("rstInstRdata", inst_rdata, 0);
      checkOutput("rstDataRdata", data_rdata, 0);
      checkOutput("rstStall", stall_o, inst_req | data_req);
    end else begin
      complete  = mBusy && bus_data_ok && (mAccepted || bus_addr_ok);
      flushNow  = mBusy && !mOwnData && inst_flush;
      expInstOk = complete && !mOwnData && !mDropped && !flushNow;
      expDataOk = complete && mOwnData;
      expBusReq = mBusy && !mAccepted;
      checkOutput("modelInstOk", inst_data_ok, expInstOk);
      checkOutput("modelDataOk", data_data_ok, expDataOk);
      checkOutput("modelBusReq", bus_req, expBusReq);
      checkOutput("modelStall", stall_o,
                  (inst_req & !expInstOk) | (data_req & !expDataOk));
      if (expInstOk) checkOutput("modelInstRdata", inst_rdata, bus_rdata);
      if (expDataOk) checkOutput("modelDataRdata", data_rdata, bus_rdata);
      if (expBusReq) begin
        checkOutput("modelBusAddr", bus_addr, mAddr);
        checkOutput("modelBusWr", bus_wr, mWr);
        checkOutput("modelBusWen", bus_wen, mWen);
        if (mOwnData) checkOutput("modelBusWdata", bus_wdata, mWdata);
      end
      if (!mBusy) begin
        if (inst_req || data_req) begin
          mBusy = 1; mAccepted = 0; mDropped = 0;
          mOwnData = data_req && (!inst_req || DATA_FIRST_TB);
          if (mOwnData) begin
            mAddr = data_addr; mWr = data_wr; mWen = data_wen; mWdata = data_wdata;
          end else begin
            mAddr = inst_addr; mWr = 0; mWen = 4'b0000;
          end
        end
      end else if (complete) begin
        mBusy = 0;
        mDropped = 0;
      end else begin
        if (bus_addr_ok) mAccepted = 1;
        if (flushNow) mDropped = 1;
      end
    end
  end

  // Always-on handshake watcher: an unaccepted request must stay up with a
  // frozen payload, and the two completion pulses never coincide.
  logic        pRst = 1'b1;
  logic        pReq = 1'b0;
  logic        pAok = 1'b0;
  logic [31:0] pAddr = '0;
  logic        pWr = 1'b0;
  logic [3:0]  pWen = '0;
  logic [31:0] pWdata = '0;

  always @(negedge clk) begin
    if (!rst && !pRst && pReq && !pAok) begin
      checkOutput("holdBusReq", bus_req, 1);
      checkOutput("holdBusAddr", bus_addr, pAddr);
      checkOutput("holdBusWr", bus_wr, pWr);
      checkOutput("holdBusWen", bus_wen, pWen);
      checkOutput("holdBusWdata", bus_wdata, pWdata);
    end
    if (inst_data_ok || data_data_ok) begin
      checkOutput("okExclusive", inst_data_ok & data_data_ok, 0);
    end
    pRst = rst; pReq = bus_req; pAok = bus_addr_ok;
    pAddr = bus_addr; pWr = bus_wr; pWen = bus_wen; pWdata = bus_wdata;
  end

  // Directed scenarios; each step is one clock cycle, literal checks are
  // taken on the falling edge in the middle of that cycle.
  initial begin
    rst = 1'b1;
    inst_req = 0; inst_addr = '0; inst_flush = 0;
    data_req = 0; data_wr = 0; data_wen = '0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;

    // Reset state
    @(negedge clk);
    checkOutput("resetBusReq", bus_req, 0);
    checkOutput("resetBusAddr", bus_addr, 0);
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    // Lone fetch: addr_ok in cycle 2, data_ok in cycle 4
    $display("[TB] lone fetch");
    inst_req = 1; inst_addr = 32'hBFC00000;
    @(negedge clk);
    checkOutput("fetchIdleBusReq", bus_req, 0);
    checkOutput("fetchIdleStall", stall_o, 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("fetchBusReq", bus_req, 1);
    checkOutput("fetchBusAddr", bus_addr, 32'hBFC00000);
    checkOutput("fetchBusWen", bus_wen, 0);
    applyStimulus();
    bus_addr_ok = 1;
    @(negedge clk);
    checkOutput("fetchBusReqHeld", bus_req, 1);
    applyStimulus();
    bus_addr_ok = 0;
    @(negedge clk);
    checkOutput("fetchWaitBusReq", bus_req, 0);
    checkOutput("fetchWaitInstOk", inst_data_ok, 0);
    applyStimulus();
    bus_data_ok = 1; bus_rdata = 32'h24020001;
    @(negedge clk);
    checkOutput("fetchInstOk", inst_data_ok, 1);
    checkOutput("fetchInstRdata", inst_rdata, 32'h24020001);
    checkOutput("fetchDoneStall", stall_o, 0);
    applyStimulus();
    bus_data_ok = 0; inst_req = 0;
    @(negedge clk);
    checkOutput("fetchOkOneCycle", inst_data_ok, 0);
    applyStimulus();

    // Simultaneous fetch and store, data wins
    $display("[TB] fetch and store together");
    inst_req = 1; inst_addr = 32'hBFC00004;
    data_req = 1; data_wr = 1; data_wen = 4'b1111;
    data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
    applyStimulus();
    bus_addr_ok = 1;
    @(negedge clk);
    checkOutput("bothBusAddr", bus_addr, 32'h80001000);
    checkOutput("bothBusWr", bus_wr, 1);
    checkOutput("bothBusWen", bus_wen, 4'b1111);
    checkOutput("bothBusWdata", bus_wdata, 32'hDEADBEEF);
    applyStimulus();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0;
    @(negedge clk);
    checkOutput("bothDataOk", data_data_ok, 1);
    checkOutput("bothInstNotOk", inst_data_ok, 0);
    applyStimulus();
    bus_data_ok = 0; data_req = 0; data_wr = 0; data_wen = '0;
    @(negedge clk);
    checkOutput("bothGapBusReq", bus_req, 0);
    checkOutput("bothGapStall", stall_o, 1);
    applyStimulus();
    bus_addr_ok = 1;
    @(negedge clk);
    checkOutput("bothInstBusReq", bus_req, 1);
    checkOutput("bothInstBusAddr", bus_addr, 32'hBFC00004);
    checkOutput("bothInstBusWr", bus_wr, 0);
    applyStimulus();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h00000013;
    @(negedge clk);
    checkOutput("bothInstOk", inst_data_ok, 1);
    checkOutput("bothInstRdata", inst_rdata, 32'h00000013);
    applyStimulus();
    bus_data_ok = 0; inst_req = 0;
    applyStimulus();

    // Flush while the fetch waits for data
    $display("[TB] flush during fetch");
    inst_req = 1; inst_addr = 32'hBFC00008;
    applyStimulus();
    bus_addr_ok = 1;
    applyStimulus();
    bus_addr_ok = 0; inst_flush = 1;
    applyStimulus();
    inst_flush = 0; inst_addr = 32'hBFC00100;
    bus_data_ok = 1; bus_rdata = 32'hAAAA5555;
    @(negedge clk);
    checkOutput("flushNoInstOk", inst_data_ok, 0);
    applyStimulus();
    bus_data_ok = 0;
    @(negedge clk);
    checkOutput("flushIdleBusReq", bus_req, 0);
    applyStimulus();
    bus_addr_ok = 1;
    @(negedge clk);
    checkOutput("flushNextBusReq", bus_req, 1);
    checkOutput("flushNextBusAddr", bus_addr, 32'hBFC00100);
    applyStimulus();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C1D8000;
    @(negedge clk);
    checkOutput("flushNextInstOk", inst_data_ok, 1);
    checkOutput("flushNextRdata", inst_rdata, 32'h3C1D8000);
    applyStimulus();
    bus_data_ok = 0; inst_req = 0;
    applyStimulus();

    // Load with addr_ok and data_ok together; a flush on a data
    // transaction must not disturb it
    $display("[TB] combined handshake load");
    data_req = 1; data_wr = 0; data_wen = 4'b0000; data_addr = 32'h80002000;
    applyStimulus();
    bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h12345678; inst_flush = 1;
    @(negedge clk);
    checkOutput("comboDataOk", data_data_ok, 1);
    checkOutput("comboDataRdata", data_rdata, 32'h12345678);
    applyStimulus();
    bus_addr_ok = 0; bus_data_ok = 0; inst_flush = 0; data_req = 0;
    @(negedge clk);
    checkOutput("comboIdleDataOk", data_data_ok, 0);
    checkOutput("comboIdleBusReq", bus_req, 0);
    applyStimulus();

    // Reset while waiting for load data
    $display("[TB] reset in wait");
    data_req = 1; data_wr = 0; data_addr = 32'h80003000;
    applyStimulus();
    bus_addr_ok = 1;
    applyStimulus();
    bus_addr_ok = 0; rst = 1;
    #1;
    checkOutput("rstMidBusAddr", bus_addr, 0);
    checkOutput("rstMidDataOk", data_data_ok, 0);
    checkOutput("rstMidStall", stall_o, 1);
    applyStimulus();
    bus_data_ok = 1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checkOutput("rstHeldDataOk", data_data_ok, 0);
    applyStimulus();
    rst = 0; data_req = 0;
    @(negedge clk);
    checkOutput("rstLateDataOk", data_data_ok, 0);
    checkOutput("rstLateBusReq", bus_req, 0);
    applyStimulus();
    bus_data_ok = 0;
    applyStimulus();
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
